// File: rtl/frame_config_loader.sv
// Configuration front end: frames a 32-bit bitstream into per-row FrameData words and a one-hot FrameStrobe per frame.
// Latency: FrameStrobe rises one cycle after the last data word; WriteReady drops for the STROBE and HOLD cycles only.
module frame_config_loader #(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 20,
  parameter int          NumberOfRows    = 16,
  parameter int          NumberOfCols    = 16,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
  input  logic                                      CLK,
  input  logic                                      resetn,
  input  logic [31:0]                               WriteData,
  input  logic                                      WriteStrobe,
  output logic                                      WriteReady,
  output logic [NumberOfRows*FrameBitsPerRow-1:0]   FrameData,
  output logic [NumberOfCols*MaxFramesPerCol-1:0]   FrameStrobe,
  output logic                                      ConfigActive,
  output logic                                      ConfigError
);
  localparam int RowW    = (NumberOfRows > 1)    ? $clog2(NumberOfRows)    : 1;
  localparam int ColW    = (NumberOfCols > 1)    ? $clog2(NumberOfCols)    : 1;
  localparam int FrmW    = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int StrobeW = NumberOfCols * MaxFramesPerCol;
  localparam logic [RowW-1:0] LastRow = RowW'(NumberOfRows - 1);

  typedef enum logic [2:0] {IDLE, HEADER, DATA, STROBE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [RowW-1:0] row_q;
  logic [ColW-1:0] col_q;
  logic [FrmW-1:0] frame_q;
  logic            hdr_bad, hdr_load, data_we, last_row, err_set, err_clr;
  logic [31:0]     hdr_col, hdr_frame, strobe_idx;

  // Range checks use the full 8-bit header fields so out-of-range values are not aliased by truncation.
  assign hdr_col    = {24'd0, WriteData[15:8]};
  assign hdr_frame  = {24'd0, WriteData[7:0]};
  assign hdr_bad    = (hdr_col >= 32'(NumberOfCols)) || (hdr_frame >= 32'(MaxFramesPerCol));
  assign last_row   = (row_q == LastRow);
  assign strobe_idx = 32'(col_q) * 32'(MaxFramesPerCol) + 32'(frame_q);
  assign WriteReady = (state == IDLE) || (state == HEADER) || (state == DATA);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hdr_load  = 1'b0;
    data_we   = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (WriteStrobe && (WriteData == SyncWord)) begin
          state_nxt = HEADER;
          err_clr   = 1'b1;
        end
      end
      HEADER: begin
        // The sync word has bit 31 set, so it must be matched before the desync bit.
        if (WriteStrobe) begin
          if (WriteData == SyncWord) begin
            state_nxt = HEADER;
          end else if (WriteData[31]) begin
            state_nxt = IDLE;
          end else if (hdr_bad) begin
            err_set   = 1'b1;
            state_nxt = IDLE;
          end else begin
            hdr_load  = 1'b1;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (WriteStrobe) begin
          data_we = 1'b1;
          if (last_row) state_nxt = STROBE;
        end
      end
      STROBE:  state_nxt = HOLD;
      HOLD:    state_nxt = HEADER;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      row_q        <= '0;
      col_q        <= '0;
      frame_q      <= '0;
      ConfigError  <= 1'b0;
      ConfigActive <= 1'b0;
      FrameStrobe  <= '0;
    end else begin
      ConfigActive <= (state_nxt != IDLE);
      FrameStrobe  <= '0;
      if (err_clr)      ConfigError <= 1'b0;
      else if (err_set) ConfigError <= 1'b1;
      if (hdr_load) begin
        col_q   <= WriteData[8 +: ColW];
        frame_q <= WriteData[0 +: FrmW];
        row_q   <= '0;
      end
      if (data_we) begin
        if (!last_row) row_q       <= row_q + RowW'(1);
        else           FrameStrobe <= StrobeW'(1) << strobe_idx;
      end
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      FrameData <= '0;
    end else if (data_we) begin
      for (int r = 0; r < NumberOfRows; r++) begin
        if (row_q == RowW'(r)) FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= WriteData;
      end
    end
  end

endmodule

// File: doc/frame_config_loader.md
# frame_config_loader

Configuration front end for the fabric: accepts a 32-bit bitstream word stream and drives the row-shared `FrameData` buses and the per-column `FrameStrobe` buses that enter the top of every tile column (N_IO4 and its peers). The block sits directly upstream of the N-IO tile row. It frames the stream with a sync word and per-frame headers, assembles one data word per fabric row, then fires a single-cycle one-hot strobe into the addressed column/frame. The tiles' config latches capture on that strobe.

## Interface
- `FrameBitsPerRow`, 32: width of one row's FrameData; fixed equal to the word width.
- `MaxFramesPerCol`, 20: frames per column; equals the FrameStrobe width per column.
- `NumberOfRows`, 16: fabric rows; number of data words per frame.
- `NumberOfCols`, 16: fabric columns.
- `SyncWord`, 32'hFAB0_FAB1: stream sync pattern.
- `CLK`  in  1  configuration clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `WriteData`  in  32  bitstream word.
- `WriteStrobe`  in  1  word valid; a word transfers when `WriteStrobe && WriteReady` on a CLK edge.
- `WriteReady`  out  1  loader can accept a word.
- `FrameData`  out  NumberOfRows*FrameBitsPerRow  row k occupies `[k*32 +: 32]`.
- `FrameStrobe`  out  NumberOfCols*MaxFramesPerCol  column c, frame f is bit `c*MaxFramesPerCol+f`.
- `ConfigActive`  out  1  high while synced, i.e. not in IDLE.
- `ConfigError`  out  1  sticky header error flag.

## Operation
- States: IDLE, HEADER, DATA, STROBE, HOLD.
- **IDLE**
  - `WriteReady`=1.
  - Transferred words other than `SyncWord` are discarded.
  - `SyncWord` goes to HEADER and clears `ConfigError`.
- **HEADER**
  - `WriteReady`=1.
  - Header fields: [31] desync, [15:8] column, [7:0] frame; [30:16] are ignored.
  - desync=1 goes to IDLE.
  - `SyncWord` leaves the state in HEADER (re-sync tolerated).
  - column ≥ NumberOfCols or frame ≥ MaxFramesPerCol sets `ConfigError` and goes to IDLE.
  - Otherwise latch col/frame, clear the row counter, and go to DATA.
- **DATA**
  - `WriteReady`=1.
  - Each transferred word is written to FrameData row = row counter, then the row counter increments.
  - Data words are never interpreted; `SyncWord` and bit 31 are plain data here.
  - The transfer with row counter = NumberOfRows-1 goes to STROBE.
- **STROBE**
  - `WriteReady`=0.
  - Exactly the addressed FrameStrobe bit is 1 for this one cycle; all other bits are 0.
  - Go to HOLD.
- **HOLD**
  - `WriteReady`=0.
  - FrameStrobe is all 0; this cycle gives the latches hold time.
  - Go to HEADER.
- FrameData changes only on a DATA-state transfer to the written row; it is otherwise held, including across frames and in IDLE.
- FrameStrobe is a registered output driven from the latched col/frame; it is never combinational from inputs.
- Row counter width is `$clog2(NumberOfRows)`, minimum 1; it never wraps past NumberOfRows-1.

## Timing
- Reset (async assert, synchronous to CLK on deassert):
  - state=IDLE.
  - FrameData=0.
  - FrameStrobe=0; must clear immediately on assert, mid-frame included.
  - ConfigError=0, ConfigActive=0.
  - WriteReady=1 after reset.
- A full frame costs 1 + NumberOfRows + 2 cycles at full throughput.
  - The last data word transfers at edge N.
  - FrameStrobe is high during cycle N..N+1.
  - HOLD occupies N+1..N+2.
  - WriteReady returns high in cycle N+2, so the next header can transfer at edge N+3.
- While WriteReady=0, `WriteStrobe` is ignored and no word is consumed; the source must hold the word.
- Gaps (WriteStrobe=0) in any state stall with no side effect.
- The last row of FrameData is stable from edge N through at least the end of HOLD.
- The other rows are stable from their own write edge onward.
- ConfigActive is a registered decode of state≠IDLE.

## Test plan
- **Reset mid-frame:**
  - Stimulus: sync, header col 2 frame 3, then 5 data words; pulse resetn low for 1 ns asynchronously.
  - Required: FrameStrobe=0 and FrameData=0 immediately; state IDLE; the next words before a sync are discarded.
- **Basic frame:**
  - Stimulus: sync, header 0x0000_0305 (col 3, frame 5), 16 words 0x100+k.
  - Required: row k = 0x100+k; FrameStrobe bit 65 high for exactly 1 cycle, one cycle after the last word; WriteReady low for 2 cycles.
- **Back-to-back frames:**
  - Stimulus: two frames at full rate, col 0 frame 0 then col 15 frame 19.
  - Required: strobe bit 0 then bit 319, each 1 cycle; 19 cycles between the strobes; the second frame's data does not disturb rows before their rewrite.
- **Bad header:**
  - Stimulus: header col 16 (0x0000_1000).
  - Required: ConfigError=1, ConfigActive=0, no strobe.
  - Stimulus: then SyncWord.
  - Required: ConfigError=0.
- **Desync and data-looking sync:**
  - Stimulus: frame whose data word 4 = 0xFAB0_FAB1.
  - Required: stored as data, strobe fires normally.
  - Stimulus: then header 0x8000_0000.
  - Required: IDLE, ConfigActive=0.
- **Stalls:**
  - Stimulus: random WriteStrobe gaps, and WriteStrobe held high through STROBE/HOLD.
  - Required: results identical to the gap-free run; no word consumed while WriteReady=0.
